sonar_scan_uc: RTL

Parametrised sonar scan control unit. It sequences servo settling, distance measurement and multi-byte serial report transmission over a configurable number of angular positions, with selectable ping-pong or wrap-around sweep. It sits between the servo/position datapath, the ultrasonic sensor interface and the serial transmitter, and drives the selects of the report multiplexer.

---
 rtl/sonar_scan_uc.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sonar_scan_uc.sv
// Sonar scan control unit: servo settle, measure, multi-byte report, then step the position.
// Define SONAR_TIMEOUT_EN to add the measurement timeout, the FALHA state and erro_medida.
module sonar_scan_uc #(
  parameter int unsigned N_POS          = 8,
  parameter int unsigned TX_BYTES       = 8,
  parameter int unsigned SETTLE_CYCLES  = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  localparam int unsigned POS_W = (N_POS > 1) ? $clog2(N_POS) : 1,
  localparam int unsigned TX_W  = (TX_BYTES > 1) ? $clog2(TX_BYTES) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ligar,
  input  logic             modo,
  input  logic             sensor_pronto,
  input  logic             serial_pronto,
  output logic             medicao,
  output logic             transmissao,
  output logic [TX_W-1:0]  sel_transmissao,
  output logic [POS_W-1:0] sel_posicao,
  output logic             fim_posicao,
  output logic             fim_varredura,
  output logic             erro_medida,
  output logic [3:0]       estado
);

  // One counter serves both the settle wait and the measurement timeout.
  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES
                                                                     : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [POS_W-1:0] POS_LAST    = POS_W'(N_POS - 1);
  localparam logic [POS_W-1:0] POS_TURN    = POS_W'((N_POS > 1) ? N_POS - 2 : 0);
  localparam logic [TX_W-1:0]  TX_LAST     = TX_W'(TX_BYTES - 1);

  typedef enum logic [2:0] {
    StInicial = 3'd0,
    StEspera  = 3'd1,
    StMedir   = 3'd2,
    StTx      = 3'd3,
    StProxPos = 3'd4,
    StFalha   = 3'd5
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [TX_W-1:0]  tx_idx_q;
  logic [POS_W-1:0] pos_q;
  logic             desc_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StInicial;
      cnt_q    <= '0;
      tx_idx_q <= '0;
      pos_q    <= '0;
      desc_q   <= 1'b0;
    end else if (!ligar) begin
      state_q  <= StInicial;
      cnt_q    <= '0;
      tx_idx_q <= '0;
    end else begin
      cnt_q <= '0;
      case (state_q)
        StInicial: state_q <= StEspera;
        StEspera: begin
          if (cnt_q == SETTLE_LAST) state_q <= StMedir;
          else                      cnt_q   <= cnt_q + 1'b1;
        end
        StMedir: begin
          if (sensor_pronto) state_q <= StTx;
`ifdef SONAR_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) state_q <= StFalha;
          else cnt_q <= cnt_q + 1'b1;
`endif
        end
        StFalha: state_q <= StTx;
        StTx: begin
          if (serial_pronto) begin
            if (tx_idx_q == TX_LAST) begin
              tx_idx_q <= '0;
              state_q  <= StProxPos;
            end else begin
              tx_idx_q <= tx_idx_q + 1'b1;
            end
          end
        end
        StProxPos: begin
          state_q <= StEspera;
          if (modo) begin
            desc_q <= 1'b0;
            pos_q  <= (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
          end else if (N_POS > 1) begin
            // Ping-pong: the end positions are visited once per turn-around.
            if (!desc_q) begin
              if (pos_q == POS_LAST) begin
                pos_q  <= POS_TURN;
                desc_q <= 1'b1;
              end else begin
                pos_q <= pos_q + 1'b1;
              end
            end else begin
              if (pos_q == '0) begin
                pos_q  <= POS_W'(1);
                desc_q <= 1'b0;
              end else begin
                pos_q <= pos_q - 1'b1;
              end
            end
          end
        end
        default: state_q <= StInicial;
      endcase
    end
  end

`ifdef SONAR_TIMEOUT_EN
  logic erro_q;

  // Tracks the MEDIR exits taken by the state register above.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      erro_q <= 1'b0;
    end else if (ligar) begin
      if (state_q == StMedir && !sensor_pronto && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        erro_q <= 1'b1;
      end else if (state_q == StEspera && cnt_q == SETTLE_LAST) begin
        erro_q <= 1'b0;
      end
    end
  end

  assign erro_medida = erro_q;
`else
  assign erro_medida = 1'b0;
`endif

  assign estado          = {1'b0, state_q};
  assign medicao         = (state_q == StMedir);
  assign transmissao     = (state_q == StTx);
  assign fim_posicao     = (state_q == StProxPos);
  assign fim_varredura   = (state_q == StProxPos) &&
                           ((pos_q == POS_LAST && !desc_q) || (pos_q == '0 && desc_q));
  assign sel_transmissao = tx_idx_q;
  assign sel_posicao     = pos_q;

endmodule
